// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
// Shared types and constants for the multi-cycle MIPS control FSM:
//   - state_e     : FSM state encoding
//   - opcode / funct constants for the supported instruction subset
//   - ALU operation codes, pc_src and alu_src_b encodings
//   - ctrl_t      : bundle of Moore-decoded control outputs
//   - ctrl_decode : maps a state (plus instruction context) to its ctrl_t
// -----------------------------------------------------------------------------
package multicycle_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR,
    MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, TRAP
  } state_e;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd7;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // Moore part of the control outputs. fetch/branch mark the two states whose
  // pc_wren (and ir_wren) are further qualified by inputs at the top level.
  typedef struct packed {
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             fetch;
    logic             branch;
    logic             pc_wren;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [ALU_W-1:0] alu_control;
    logic             reg_file_wren;
    logic             rmux;
    logic             dmux;
  } ctrl_t;

  // from_r : previous state was EXEC_R (selects rd as write address in WB_ALU)
  // r_alu  : ALU code decoded from funct (used in EXEC_R)
  // r_jr   : funct is jr (EXEC_R redirects the PC to rs)
  function automatic ctrl_t ctrl_decode(input state_e s, input logic from_r,
                                        input logic [ALU_W-1:0] r_alu,
                                        input logic r_jr);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req     = 1'b1;
        c.fetch       = 1'b1;
        c.alu_src_b   = SRCB_FOUR;
        c.alu_control = ALU_ADD;
        c.pc_src      = PC_ALU;
      end
      DECODE: begin
        // Branch target precomputed into ALUOut.
        c.alu_src_b   = SRCB_IMM_SH2;
        c.alu_control = ALU_ADD;
      end
      EXEC_R: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_RT;
        c.alu_control = r_alu;
        if (r_jr) begin
          c.pc_wren = 1'b1;
          c.pc_src  = PC_RS;
        end
      end
      EXEC_I, MEM_ADDR: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = ALU_ADD;
      end
      WB_ALU: begin
        c.reg_file_wren = 1'b1;
        c.dmux          = 1'b1;
        c.rmux          = from_r;
      end
      MEM_RD: begin
        c.mem_req      = 1'b1;
        c.mem_addr_sel = 1'b1;
      end
      WB_MEM: begin
        c.reg_file_wren = 1'b1;
      end
      MEM_WR: begin
        c.mem_req      = 1'b1;
        c.mem_we       = 1'b1;
        c.mem_addr_sel = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_RT;
        c.alu_control = ALU_SUB;
        c.pc_src      = PC_ALUOUT;
        c.branch      = 1'b1;
      end
      JUMP: begin
        c.pc_wren = 1'b1;
        c.pc_src  = PC_JUMP;
      end
      default: c = '0; // TRAP: everything quiet
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// -----------------------------------------------------------------------------
// mc_alu_decode
// Combinational funct -> ALU operation mapping for R-type instructions.
// Ports:
//   funct       in  6      instruction[5:0]
//   alu_control out ALU_W  ALU operation code (ADD for unsupported functs)
//   illegal     out 1      funct is not one of the supported ALU functs
// jr is not an ALU operation and reports illegal here; the FSM checks jr first.
// -----------------------------------------------------------------------------
module mc_alu_decode
  import multicycle_pkg::*;
(
  input  logic [5:0]       funct,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      FN_SLL:  alu_control = ALU_SLL;
      FN_SRL:  alu_control = ALU_SRL;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle MIPS control FSM. Sequences each instruction through
// fetch/decode/execute/memory/writeback over one shared memory port.
//
// Memory handshake: mem_req is held high (with mem_we/mem_addr_sel stable)
// until a cycle where mem_ack=1; that cycle completes the access, including
// the first request cycle. mem_ack is ignored while mem_req=0. If MEM_TIMEOUT
// consecutive request cycles pass without ack, the FSM traps with bus_error
// (an ack in the final cycle still completes the access).
//
// Ports:
//   clk, rst (async, active-low)
//   opcode, funct, alu_zero, mem_ack              : inputs
//   mem_req, mem_we, mem_addr_sel                 : memory port control
//   ir_wren, pc_wren, pc_src                      : IR / PC control
//   alu_src_a, alu_src_b, alu_control             : ALU control
//   reg_file_wren, reg_file_rmux_select,
//   reg_file_dmux_select                          : register file control
//   illegal, bus_error                            : sticky trap causes
//   instr_retired, mem_stall_cycles               : performance counters
//
// Optional feature: define MULTICYCLE_CONTROL_PERF_CNT_EN to build the
// performance counters; otherwise both counter ports read 0.
// -----------------------------------------------------------------------------
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALU_CTRL_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  alu_zero,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_addr_sel,
  output logic                  ir_wren,
  output logic                  pc_wren,
  output logic [1:0]            pc_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  reg_file_wren,
  output logic                  reg_file_rmux_select,
  output logic                  reg_file_dmux_select,
  output logic                  illegal,
  output logic                  bus_error,
  output logic [31:0]           instr_retired,
  output logic [31:0]           mem_stall_cycles
);

  localparam int TMO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (MEM_TIMEOUT > 0);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  // Control value held while in (and just out of) reset: the FETCH decode.
  localparam ctrl_t CTRL_RESET = ctrl_decode(FETCH, 1'b0, ALU_ADD, 1'b0);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             illegal_q, illegal_d;
  logic             bus_error_q, bus_error_d;

  logic [ALU_W-1:0] r_alu;
  logic             r_alu_illegal;
  logic             r_jr;
  logic             waiting;
  logic             tmo_hit;
  logic             br_take;

  mc_alu_decode u_alu_decode (
    .funct       (funct),
    .alu_control (r_alu),
    .illegal     (r_alu_illegal)
  );

  assign r_jr    = (funct == FN_JR);
  assign waiting = ctrl_q.mem_req & ~mem_ack;
  // The last allowed wait cycle: no ack now means the bus has timed out.
  assign tmo_hit = TMO_EN && waiting && (tmo_q == TMO_LAST);
  assign br_take = (opcode == OP_BNE) ? ~alu_zero : alu_zero;

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    case (state_q)
      FETCH: begin
        if (mem_ack) begin
          state_d = DECODE;
        end else if (tmo_hit) begin
          state_d     = TRAP;
          bus_error_d = 1'b1;
        end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = EXEC_R;
          OP_ADDI:       state_d = EXEC_I;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:          state_d = JUMP;
          default: begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        if (r_jr) begin
          state_d = FETCH;
        end else if (r_alu_illegal) begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = WB_ALU;
        end
      end
      EXEC_I:   state_d = WB_ALU;
      MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD, MEM_WR: begin
        if (mem_ack) begin
          state_d = (state_q == MEM_RD) ? WB_MEM : FETCH;
        end else if (tmo_hit) begin
          state_d     = TRAP;
          bus_error_d = 1'b1;
        end
      end
      WB_ALU, WB_MEM, BRANCH, JUMP: state_d = FETCH;
      default: state_d = TRAP;
    endcase
  end

  // Outputs are registered: decode of the next state, computed one cycle early.
  always_comb begin
    ctrl_d = ctrl_decode(state_d, (state_q == EXEC_R), r_alu, r_jr);
    tmo_d  = (waiting && (state_d == state_q)) ? tmo_q + TMO_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      ctrl_q      <= CTRL_RESET;
      tmo_q       <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      tmo_q       <= tmo_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Reset forces every request, enable and select low immediately.
  assign mem_req              = rst & ctrl_q.mem_req;
  assign mem_we               = rst & ctrl_q.mem_we;
  assign mem_addr_sel         = rst & ctrl_q.mem_addr_sel;
  assign ir_wren              = rst & ctrl_q.fetch & mem_ack;
  assign pc_wren              = rst & (ctrl_q.pc_wren
                                       | (ctrl_q.fetch & mem_ack)
                                       | (ctrl_q.branch & br_take));
  assign pc_src               = rst ? ctrl_q.pc_src : 2'b00;
  assign alu_src_a            = rst & ctrl_q.alu_src_a;
  assign alu_src_b            = rst ? ctrl_q.alu_src_b : 2'b00;
  assign alu_control          = rst ? ALU_CTRL_W'(ctrl_q.alu_control) : '0;
  assign reg_file_wren        = rst & ctrl_q.reg_file_wren;
  assign reg_file_rmux_select = rst & ctrl_q.rmux;
  assign reg_file_dmux_select = rst & ctrl_q.dmux;
  assign illegal              = illegal_q;
  assign bus_error            = bus_error_q;

`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      // Every path back to FETCH completes an instruction.
      if ((state_d == FETCH) && (state_q != FETCH)) begin
        retired_q <= retired_q + 32'd1;
      end
      if (waiting) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign instr_retired    = retired_q;
  assign mem_stall_cycles = stall_q;
`else
  assign instr_retired    = '0;
  assign mem_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  opcode, funct;
  logic        alu_zero, mem_ack;

  logic        mem_req, mem_we, mem_addr_sel, ir_wren, pc_wren;
  logic [1:0]  pc_src, alu_src_b;
  logic        alu_src_a;
  logic [3:0]  alu_control;
  logic        reg_file_wren, rmux, dmux, illegal, bus_error;
  logic [31:0] instr_retired, mem_stall_cycles;

  // second instance with the bus timeout disabled
  logic        z_mem_req, z_mem_we, z_mem_addr_sel, z_ir_wren, z_pc_wren;
  logic [1:0]  z_pc_src, z_alu_src_b;
  logic        z_alu_src_a;
  logic [3:0]  z_alu_control;
  logic        z_reg_file_wren, z_rmux, z_dmux, z_illegal, z_bus_error;
  logic [31:0] z_instr_retired, z_mem_stall_cycles;

  multicycle_control #(.MEM_TIMEOUT(15), .ALU_CTRL_W(4)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_wren(ir_wren), .pc_wren(pc_wren), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_file_wren(reg_file_wren), .reg_file_rmux_select(rmux),
    .reg_file_dmux_select(dmux), .illegal(illegal), .bus_error(bus_error),
    .instr_retired(instr_retired), .mem_stall_cycles(mem_stall_cycles)
  );

  multicycle_control #(.MEM_TIMEOUT(0), .ALU_CTRL_W(4)) u_dut_notmo (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ack(mem_ack),
    .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_addr_sel(z_mem_addr_sel),
    .ir_wren(z_ir_wren), .pc_wren(z_pc_wren), .pc_src(z_pc_src),
    .alu_src_a(z_alu_src_a), .alu_src_b(z_alu_src_b), .alu_control(z_alu_control),
    .reg_file_wren(z_reg_file_wren), .reg_file_rmux_select(z_rmux),
    .reg_file_dmux_select(z_dmux), .illegal(z_illegal), .bus_error(z_bus_error),
    .instr_retired(z_instr_retired), .mem_stall_cycles(z_mem_stall_cycles)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks; every cycle starts 1 time unit after the rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic do_reset();
    mem_ack = 1'b0;
    rst     = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Zero-wait instruction fetch; returns at the start of the DECODE cycle.
  task automatic fetch_cycle(input logic [5:0] op, input logic [5:0] fn, input string tag);
    opcode  = op;
    funct   = fn;
    mem_ack = 1'b1;
    mid();
    check({tag, "_fetch_req"}, mem_req, 1);
    check({tag, "_ir_wren"}, ir_wren, 1);
    check({tag, "_fetch_pc_wren"}, pc_wren, 1);
    nxt();
    mem_ack = 1'b0;
  endtask

  int cnt;
  int bad;

  initial begin
    rst = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ack = 1'b1;

    // reset state: all outputs forced low even with mem_ack high
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_ir_wren", ir_wren, 0);
    check("rst_pc_wren", pc_wren, 0);
    check("rst_alu_src_b", alu_src_b, 0);
    check("rst_alu_control", alu_control, 0);
    check("rst_illegal", illegal, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_retired", instr_retired, 0);
    @(posedge clk); #1; rst = 1'b1;

    // add $3,$1,$2
    fetch_cycle(6'h00, 6'h20, "add");
    mid();
    check("add_dec_srcb", alu_src_b, 3);
    check("add_dec_req", mem_req, 0);
    nxt(); mid();
    check("add_ex_alu", alu_control, 2);
    check("add_ex_srca", alu_src_a, 1);
    check("add_ex_srcb", alu_src_b, 0);
    check("add_ex_wren", reg_file_wren, 0);
    nxt(); mid();
    check("add_wb_wren", reg_file_wren, 1);
    check("add_wb_rmux", rmux, 1);
    check("add_wb_dmux", dmux, 1);
    nxt();
    check("add_retired", instr_retired, PERF * 1);
    mid();
    check("add_back_fetch", mem_req, 1);

    // lw with three wait states
    do_reset();
    fetch_cycle(6'h23, 6'h04, "lw");
    nxt(); mid();
    check("lw_addr_srca", alu_src_a, 1);
    check("lw_addr_srcb", alu_src_b, 2);
    nxt();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      mid();
      if (mem_req === 1'b1 && mem_addr_sel === 1'b1 && mem_we === 1'b0) cnt++;
      nxt();
    end
    mem_ack = 1'b0;
    check("lw_req_cycles", cnt, 4);
    mid();
    check("lw_wb_wren", reg_file_wren, 1);
    check("lw_wb_rmux", rmux, 0);
    check("lw_wb_dmux", dmux, 0);
    nxt();
    check("lw_stalls", mem_stall_cycles, PERF * 3);
    check("lw_retired", instr_retired, PERF * 1);

    // beq taken, bne not taken / taken, j, jr, addi, sw
    do_reset();
    alu_zero = 1'b1;
    fetch_cycle(6'h04, 6'h00, "beq");
    nxt(); mid();
    check("beq_pc_wren", pc_wren, 1);
    check("beq_pc_src", pc_src, 1);
    check("beq_alu", alu_control, 6);
    nxt();
    fetch_cycle(6'h05, 6'h00, "bne");
    nxt(); mid();
    check("bne_pc_wren_z1", pc_wren, 0);
    check("bne_pc_src", pc_src, 1);
    alu_zero = 1'b0;
    #1;
    check("bne_pc_wren_z0", pc_wren, 1);
    nxt();
    fetch_cycle(6'h02, 6'h00, "j");
    nxt(); mid();
    check("j_pc_wren", pc_wren, 1);
    check("j_pc_src", pc_src, 2);
    nxt();
    fetch_cycle(6'h00, 6'h08, "jr");
    nxt(); mid();
    check("jr_pc_wren", pc_wren, 1);
    check("jr_pc_src", pc_src, 3);
    nxt();
    fetch_cycle(6'h08, 6'h00, "addi");
    nxt(); mid();
    check("addi_srcb", alu_src_b, 2);
    nxt(); mid();
    check("addi_wb_wren", reg_file_wren, 1);
    check("addi_wb_rmux", rmux, 0);
    nxt();
    fetch_cycle(6'h2B, 6'h00, "sw");
    nxt(); nxt();
    mem_ack = 1'b1;
    mid();
    check("sw_we", mem_we, 1);
    check("sw_addr_sel", mem_addr_sel, 1);
    nxt();
    mem_ack = 1'b0;
    check("sw_retired", instr_retired, PERF * 6);
    mid();
    check("sw_back_fetch", alu_src_b, 1);

    // illegal opcode: absorbing trap, ack ignored
    do_reset();
    fetch_cycle(6'h3F, 6'h00, "illop");
    mid();
    check("illop_dec_flag", illegal, 0);
    nxt();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ack = i[0];
      mid();
      if (mem_req !== 1'b0 || pc_wren !== 1'b0 || ir_wren !== 1'b0) bad++;
      nxt();
    end
    mem_ack = 1'b0;
    check("illop_trap_quiet", bad, 0);
    check("illop_flag", illegal, 1);
    rst = 1'b0;
    #1;
    check("illop_rst_clear", illegal, 0);
    nxt();
    rst = 1'b1;
    mid();
    check("illop_rst_fetch", mem_req, 1);

    // illegal funct
    nxt();
    fetch_cycle(6'h00, 6'h3F, "illfn");
    nxt(); nxt(); mid();
    check("illfn_flag", illegal, 1);
    check("illfn_srca", alu_src_a, 0);

    // bus timeout in FETCH; the no-timeout instance keeps waiting
    do_reset();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      mid();
      if (mem_req === 1'b1) cnt++;
      nxt();
    end
    check("tmo_req_cycles", cnt, 15);
    check("tmo_bus_error", bus_error, 1);
    check("tmo_illegal", illegal, 0);
    check("tmo_stalls", mem_stall_cycles, PERF * 15);
    check("notmo_req", z_mem_req, 1);
    check("notmo_bus_error", z_bus_error, 0);

    // ack in the final allowed cycle wins over the timeout
    do_reset();
    for (int i = 0; i < 14; i++) begin
      nxt();
    end
    mem_ack = 1'b1;
    mid();
    check("tmo_edge_ir_wren", ir_wren, 1);
    nxt();
    mem_ack = 1'b0;
    mid();
    check("tmo_edge_bus_error", bus_error, 0);
    check("tmo_edge_decode", alu_src_b, 3);

    // reset during a MEM_WR wait abandons the access
    do_reset();
    fetch_cycle(6'h2B, 6'h00, "swr");
    nxt(); nxt();
    mid();
    check("swr_wait_req", mem_req, 1);
    check("swr_wait_we", mem_we, 1);
    #1;
    rst = 1'b0;
    #1;
    check("swr_rst_req", mem_req, 0);
    check("swr_rst_we", mem_we, 0);
    check("swr_rst_addr_sel", mem_addr_sel, 0);
    nxt();
    rst = 1'b1;
    mid();
    check("swr_post_req", mem_req, 1);
    check("swr_post_srcb", alu_src_b, 1);
    check("swr_post_addr_sel", mem_addr_sel, 0);
    check("swr_post_retired", instr_retired, 0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
